// File: rtl/piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// piso_bit_serializer
//
// Parallel-in / serial-out stage feeding the serial input of the 1010 Moore
// sequence detector. Words of WIDTH bits arrive on a valid/ready handshake.
// They leave one bit per clock, and back-to-back words have no gap between
// them. The first and last bit of every word are flagged so that detector hits
// can be aligned to word boundaries.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT   level on ser_out while no word is being sent
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   load_valid  upstream presents a word on load_data
//   load_data   word to serialize, captured on an accepted transfer
//   load_ready  block accepts a word this cycle (combinational)
//   ser_out     serial bit (registered)
//   bit_valid   ser_out carries a data bit (registered)
//   first_bit   first bit of a word is on ser_out (registered)
//   last_bit    last bit of a word is on ser_out (registered)
// -----------------------------------------------------------------------------
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   shreg_adv;
    logic               ser_out_q, ser_out_d;
    logic               bit_valid_q, bit_valid_d;
    logic               first_bit_q, first_bit_d;
    logic               last_bit_q, last_bit_d;
    logic               last_cnt;
    logic               transfer;

    // Bit that is on the wire when a given register image is current.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Advance the register by one bit position toward the output end. The
    // departing bit is wrapped into the vacated end instead of a constant; it
    // is never shown again before the word ends, and every register bit then
    // has a consumer.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_adv
            if (MSB_FIRST) begin : g_msb
                assign shreg_adv[gi] = shreg_q[(gi + WIDTH - 1) % WIDTH];
            end else begin : g_lsb
                assign shreg_adv[gi] = shreg_q[(gi + 1) % WIDTH];
            end
        end
    endgenerate

    assign last_cnt = (cnt_q == CNT_LAST);

    // Ready is high in IDLE and during the last bit of a word. It depends only
    // on state and reset, never on load_valid.
    assign load_ready = !rst && ((state_q == ST_IDLE) || last_cnt);
    assign transfer   = load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ser_out_d   = ser_out_q;
        bit_valid_d = bit_valid_q;
        first_bit_d = 1'b0;
        last_bit_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d     = ST_SHIFT;
                    cnt_d       = '0;
                    shreg_d     = load_data;
                    ser_out_d   = head_bit(load_data);
                    bit_valid_d = 1'b1;
                    first_bit_d = 1'b1;
                end else begin
                    cnt_d       = '0;
                    ser_out_d   = IDLE_BIT;
                    bit_valid_d = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (last_cnt) begin
                    if (transfer) begin
                        // Reload in the last-bit cycle: the new word's first
                        // bit follows directly, with no idle cycle.
                        state_d     = ST_SHIFT;
                        cnt_d       = '0;
                        shreg_d     = load_data;
                        ser_out_d   = head_bit(load_data);
                        bit_valid_d = 1'b1;
                        first_bit_d = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                        ser_out_d   = IDLE_BIT;
                        bit_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d       = cnt_q + CNT_ONE;
                    shreg_d     = shreg_adv;
                    ser_out_d   = head_bit(shreg_adv);
                    bit_valid_d = 1'b1;
                    // The flag registers alongside the bit it marks.
                    last_bit_d  = ((cnt_q + CNT_ONE) == CNT_LAST);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                ser_out_d   = IDLE_BIT;
                bit_valid_d = 1'b0;
            end
        endcase
    end

    // Reset takes priority over a same-cycle transfer. A word in flight is
    // dropped and its remaining bits are never emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ser_out_q   <= IDLE_BIT;
            bit_valid_q <= 1'b0;
            first_bit_q <= 1'b0;
            last_bit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            bit_valid_q <= bit_valid_d;
            first_bit_q <= first_bit_d;
            last_bit_q  <= last_bit_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign bit_valid = bit_valid_q;
    assign first_bit = first_bit_q;
    assign last_bit  = last_bit_q;

endmodule
